// File: rtl/dtim_arbiter_if.sv
// Request/response port of one DTIM master (core data port or DMA/debug).
// The master drives the request side; the arbiter answers with gnt and the response.
interface dtim_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, wmask, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, wmask, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dtim_arbiter.sv
// Shares the single-port DTIM between m0 (core, fixed priority) and m1 (DMA/debug).
// Optional macro DTIM_ARB_STARVE_EN enables the bounded-wait starvation guard for m1.
module dtim_arbiter #(
  parameter logic [31:0] DTIM_BASE = 32'h8000_0000,
  parameter logic [31:0] DTIM_SIZE = 32'h1000_0000,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic          clk,
  input  logic          rst,
  dtim_arbiter_if.slave m0,
  dtim_arbiter_if.slave m1,
  output logic          dtim_valid,
  output logic [31:0]   dtim_addr,
  output logic [3:0]    dtim_wmask,
  output logic [31:0]   dtim_wdata,
  input  logic [31:0]   dtim_rdata
);

  localparam logic [31:0] ERR_DATA = 32'hBAAD_C0DE;

  logic        starve;
  logic        win_m0;
  logic        win_m1;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic [3:0]  sel_wmask;
  logic [31:0] sel_wdata;
  logic [31:0] offset;
  logic        in_range;
  logic        rsp_vld;
  logic        rsp_owner;
  logic        rsp_err;
  logic [31:0] rsp_data;

`ifdef DTIM_ARB_STARVE_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  logic [7:0] wait_cnt;

  assign starve = (wait_cnt == WAIT_LIMIT);

  // Counts consecutive refused m1 cycles; saturates so the guard stays armed until m1 wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (m1.req && !m1.gnt) begin
      wait_cnt <= starve ? wait_cnt : wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    win_m1    = m1.req && (starve || !m0.req);
    win_m0    = m0.req && !win_m1;
    sel_addr  = win_m1 ? m1.addr  : m0.addr;
    sel_wmask = win_m1 ? m1.wmask : m0.wmask;
    sel_wdata = win_m1 ? m1.wdata : m0.wdata;
    offset    = sel_addr - DTIM_BASE;
    in_range  = (sel_addr >= DTIM_BASE) && (offset < DTIM_SIZE);
  end

  // Grants are suppressed while reset is held so nothing reaches the macro.
  assign m0.gnt     = !rst && win_m0;
  assign m1.gnt     = !rst && win_m1;
  assign any_gnt    = m0.gnt || m1.gnt;

  assign dtim_valid = any_gnt && in_range;
  assign dtim_addr  = offset;
  assign dtim_wmask = dtim_valid ? sel_wmask : 4'b0000;
  assign dtim_wdata = sel_wdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld   <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_vld   <= any_gnt;
      rsp_owner <= m1.gnt;
      rsp_err   <= any_gnt && !in_range;
    end
  end

  // Out-of-range grants answer with a poison pattern instead of stale macro data.
  assign rsp_data  = rsp_err ? ERR_DATA : dtim_rdata;
  assign m0.rvalid = rsp_vld && !rsp_owner;
  assign m1.rvalid = rsp_vld && rsp_owner;
  assign m0.rdata  = m0.rvalid ? rsp_data : 32'h0;
  assign m1.rdata  = m1.rvalid ? rsp_data : 32'h0;

endmodule

// File: doc/dtim_arbiter.md
# dtim_arbiter

Two-port arbiter that shares the single-port data tightly-integrated memory (DTIM, base 0x8000_0000, size 0x1000_0000) between the core data port (m0) and a DMA/debug master (m1). Sits between the BIU's DTIM port and the DTIM macro. Grants at most one request per cycle, strips the DTIM base from the address, and routes the one-cycle-latency read response back to the requester that issued it. m0 has fixed priority; m1 has a bounded-wait starvation guard.

## Interface
- DTIM_BASE, 32'h8000_0000: start of the DTIM window.
- DTIM_SIZE, 32'h1000_0000: size of the DTIM window in bytes.
- MAX_WAIT, 4: cycles m1 may be refused before it takes priority; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  request valid; held with its payload until granted.
- m0_addr, m1_addr  in  32  byte address, absolute.
- m0_wmask, m1_wmask  in  4  byte write enables; 4'b0000 means read.
- m0_wdata, m1_wdata  in  32  write data.
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  out  1  response for a transaction accepted the previous cycle.
- m0_rdata, m1_rdata  out  32  read data, meaningful when rvalid is high.
- dtim_valid  out  1  DTIM access this cycle.
- dtim_addr  out  32  granted address minus DTIM_BASE.
- dtim_wmask  out  4  granted wmask; 4'b0000 when dtim_valid is low.
- dtim_wdata  out  32  granted write data.
- dtim_rdata  in  32  DTIM read data, valid the cycle after the access.

## Operation
- Arbitration, per cycle:
  - If the starvation guard fires (wait_cnt == MAX_WAIT) and m1_req is high, m1 wins.
  - Else m0 wins if m0_req is high.
  - Else m1 wins if m1_req is high.
  - Exactly one gnt, or none.
- In range: DTIM_BASE <= addr < DTIM_BASE+DTIM_SIZE.
  - A granted in-range request drives dtim_valid=1, dtim_addr=addr-DTIM_BASE, and the granted wmask/wdata.
- Out of range: the request is still granted, but dtim_valid stays 0 and the DTIM is not touched.
- Response registers, loaded every cycle: rsp_vld (a grant occurred), rsp_owner (0/1), rsp_err (grant was out of range).
- Next cycle:
  - The owner's rvalid = rsp_vld.
  - Owner rdata = rsp_err ? 32'hBAAD_C0DE : dtim_rdata.
  - The non-owner's rvalid = 0 and its rdata = 0.
  - Writes also produce rvalid, used as an acknowledge; rdata is then don't-care.
- wait_cnt, 8-bit:
  - Increments, saturating at MAX_WAIT, in each cycle m1_req=1 and m1_gnt=0.
  - Clears when m1 is granted or m1_req=0.
- Back-to-back grants are allowed every cycle with no bubble. Responses are strictly in issue order.

## Timing
- Reset values:
  - All gnt, rvalid and dtim_valid outputs are 0.
  - dtim_wmask = 4'b0000.
  - rdata outputs = 0.
  - rsp_vld = 0, rsp_owner = 0, rsp_err = 0, wait_cnt = 0.
- While rst is high, gnt outputs are forced to 0.
- A request granted in cycle N gets its rvalid in cycle N+1. Latency is 1, with no combinational path from req to rvalid.
- Reset asserted between a grant and its response: the response is dropped and no rvalid is issued after reset releases.
- Simultaneous m0_req and m1_req:
  - With wait_cnt < MAX_WAIT, m0 is granted.
  - With wait_cnt == MAX_WAIT, m1 is granted and wait_cnt clears the next cycle.

## Configuration
- DTIM_ARB_STARVE_EN defined: the starvation guard is active as described above.
- Not defined:
  - wait_cnt is removed and m0 has strict priority; m1 can starve indefinitely.
  - All other behaviour is unchanged.

## Test plan
- Reset: assert rst mid-stream -> all outputs 0 immediately; after release, no stray rvalid.
- Single read: m0 read at 0x8000_0010 with dtim_rdata=0x1234_5678 the next cycle -> dtim_addr=0x10 and dtim_valid=1 in cycle N; m0_rvalid=1 with rdata 0x1234_5678 in N+1.
- Contention: m0_req and m1_req both high continuously, MAX_WAIT=4, guard on -> m1 granted on every 5th cycle, m0 on the rest. With the macro off -> m1 never granted.
- Out of range: m1 write to 0x1001_1000, wmask 4'hF -> m1_gnt=1, dtim_valid=0, dtim_wmask=0. A later m1 read at 0x0000_0000 -> rdata=0xBAAD_C0DE one cycle after grant.
- Back-to-back alternating: m0 read in cycle N, m1 read in N+1 -> m0_rvalid in N+1, m1_rvalid in N+2, each carrying its own dtim_rdata with no cross-delivery.
- Byte write: m0 wmask=4'b0010 to 0x8000_0004 -> dtim_wmask=4'b0010, dtim_addr=0x4; m0_rvalid ack the next cycle.
